gate_resp_checker: RTL and testbench
====================================

GATE_RESP_CHECKER -- requirements
Module: gate_resp_checker

Interface
REQ-001 Parameter NUM_VECTORS, default 16, number of vectors per check run (1..255).
REQ-002 Parameter CNT_W, default 8, width of all counters and index outputs.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse; begins a run from IDLE or DONE.
REQ-006 vec_valid  input  1  vec_in/resp_in hold one stimulus/response pair.
REQ-007 vec_ready  output  1  checker accepts a pair this cycle.
REQ-008 vec_in  input  4  stimulus {a,b,c,d}, a = bit 3.
REQ-009 resp_in  input  10  observed gate outputs {o10..o2,o}, o = bit 0.
REQ-010 busy  output  1  run in progress.
REQ-011 done  output  1  run complete; held until next start.
REQ-012 pass  output  1  done with zero mismatches.
REQ-013 vec_count  output  CNT_W  pairs accepted this run.
REQ-014 err_count  output  CNT_W  mismatching pairs this run, saturating.
REQ-015 first_err_idx  output  CNT_W  vec_count value of first mismatching pair.
REQ-016 first_err_mask  output  10  XOR of expected and observed for first mismatch.

Function
REQ-017 Expected: o=a&b, o2=a|b, o3=a^b, o4=~(a&b), o5=~(a|b), o6=~(a^b), o7=~a, o8=b, o9=a&b&c&d, o10=a|b|c|d.
REQ-018 FSM states IDLE, RUN, FLUSH, DONE; reset state IDLE.
REQ-019 IDLE/DONE -> RUN on start; clear vec_count, err_count, first_err_idx, first_err_mask, done, pass.
REQ-020 vec_ready = 1 only in RUN; transfer occurs when vec_valid & vec_ready on a rising edge.
REQ-021 Transfer registers vec_in/resp_in into one pipeline stage; compare result is applied one cycle later (latency 1).
REQ-022 vec_count increments on each transfer.
REQ-023 RUN -> FLUSH on the transfer that makes vec_count reach NUM_VECTORS; vec_ready drops the following cycle.
REQ-024 FLUSH -> DONE after one cycle (last compare applied); done=1, pass=(err_count==0).
REQ-025 Mismatch (nonzero mask) increments err_count, saturating at all-ones.
REQ-026 First mismatch of a run latches first_err_idx (0-based pair index) and first_err_mask; later mismatches do not alter them.
REQ-027 busy = 1 in RUN and FLUSH.
REQ-028 start during RUN or FLUSH is ignored.
REQ-029 vec_valid outside RUN is ignored; no counter changes.
REQ-030 vec_valid low in RUN stalls without timeout; counters hold.

Reset
REQ-031 reset_n low forces, asynchronously, state IDLE and all outputs and counters to 0, including the pipeline-stage valid flag.
REQ-032 Reset mid-run discards the in-flight pair; no partial result is reported.
REQ-033 After reset release the block requires start before accepting pairs.

Structure
REQ-034 Shared package holds FSM state encoding (2-bit), output-width constant 10 and input-width constant 4.
REQ-035 Sub-module gate_ref_model: purely combinational vec_in -> 10-bit expected vector per REQ-017; instantiated once.

Verification
REQ-036 Reset, start, 16 pairs with correct responses -> done=1, pass=1, vec_count=16, err_count=0.
REQ-037 Pair 5 is vec_in=4'b1010 with resp_in bit 2 flipped -> err_count=1, first_err_idx=5, first_err_mask=10'b0000000100, pass=0.
REQ-038 Mismatches at pairs 3 and 9 -> err_count=2, first_err_idx=3, mask from pair 3 only.
REQ-039 vec_valid toggled 1/0 each cycle for 16 pairs -> vec_count=16 after 32 RUN cycles, done one cycle after FLUSH.
REQ-040 reset_n low after 7 pairs -> all outputs 0 immediately; new start plus 16 pairs -> vec_count=16.
REQ-041 start pulsed during RUN at pair 4 -> ignored; run completes with vec_count=16.

Source files
------------

// File: rtl/gate_resp_checker_pkg.sv
// Shared types and widths for the gate response checker.
// FSM state encoding plus stimulus/response vector widths.
package gate_resp_checker_pkg;

    localparam int VEC_W  = 4;
    localparam int RESP_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/gate_resp_checker_ref.sv
// Purpose: golden gate outputs for one {a,b,c,d} stimulus.
// Latency: combinational. Backpressure: none.
// Bit order is {o10..o2,o}, so o is bit 0 and o10 is bit 9.
module gate_ref_model
    import gate_resp_checker_pkg::*;
(
    input  logic [VEC_W-1:0]  vec_in,
    output logic [RESP_W-1:0] exp_out
);

    logic a, b, c, d;

    assign {a, b, c, d} = vec_in;

    assign exp_out = {
        a | b | c | d,
        a & b & c & d,
        b,
        ~a,
        ~(a ^ b),
        ~(a | b),
        ~(a & b),
        a ^ b,
        a | b,
        a & b
    };

endmodule

// File: rtl/gate_resp_checker.sv
// Purpose: checks NUM_VECTORS stimulus/response pairs against gate_ref_model.
// Latency: a compare lands one cycle after its pair is accepted.
// Backpressure: vec_ready is high only in RUN; the producer may stall indefinitely.
module gate_resp_checker
    import gate_resp_checker_pkg::*;
#(
    parameter int NUM_VECTORS = 16,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              vec_valid,
    output logic              vec_ready,
    input  logic [VEC_W-1:0]  vec_in,
    input  logic [RESP_W-1:0] resp_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  vec_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [RESP_W-1:0] first_err_mask
);

    state_t              state, state_nxt;
    logic                pipe_vld;
    logic [VEC_W-1:0]    pipe_vec;
    logic [RESP_W-1:0]   pipe_resp;
    logic [CNT_W-1:0]    pipe_idx;
    logic [RESP_W-1:0]   exp_vec;
    logic [RESP_W-1:0]   cmp_mask;
    logic                xfer, last_xfer, start_run, mism, first_mism;
    logic [CNT_W-1:0]    err_nxt;

    gate_ref_model u_ref (
        .vec_in  (pipe_vec),
        .exp_out (exp_vec)
    );

    assign vec_ready  = (state == RUN);
    assign busy       = (state == RUN) || (state == FLUSH);
    assign xfer       = vec_valid && vec_ready;
    assign last_xfer  = xfer && (vec_count == CNT_W'(NUM_VECTORS - 1));
    assign start_run  = start && ((state == IDLE) || (state == DONE));

    assign cmp_mask   = exp_vec ^ pipe_resp;
    assign mism       = pipe_vld && (cmp_mask != '0);
    // err_count is zero only until the first mismatch of a run
    assign first_mism = mism && (err_count == '0);
    assign err_nxt    = (mism && !(&err_count)) ? err_count + CNT_W'(1) : err_count;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_xfer) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pipe_vld       <= 1'b0;
            pipe_vec       <= '0;
            pipe_resp      <= '0;
            pipe_idx       <= '0;
            vec_count      <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_mask <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            state    <= state_nxt;
            pipe_vld <= xfer;
            if (xfer) begin
                pipe_vec  <= vec_in;
                pipe_resp <= resp_in;
                pipe_idx  <= vec_count;
            end
            if (start_run) begin
                vec_count      <= '0;
                err_count      <= '0;
                first_err_idx  <= '0;
                first_err_mask <= '0;
                done           <= 1'b0;
                pass           <= 1'b0;
            end else begin
                if (xfer) vec_count <= vec_count + CNT_W'(1);
                err_count <= err_nxt;
                if (first_mism) begin
                    first_err_idx  <= pipe_idx;
                    first_err_mask <= cmp_mask;
                end
                // FLUSH is the cycle the final compare lands, so use err_nxt
                if (state == FLUSH) begin
                    done <= 1'b1;
                    pass <= (err_nxt == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker: vector table, hand-written corner sequences,
// and random runs scored against an arithmetic model of the gate rules.
module tb_gate_resp_checker;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       vec_valid = 1'b0;
    logic       vec_ready;
    logic [3:0] vec_in = '0;
    logic [9:0] resp_in = '0;
    logic       busy, done, pass;
    logic [7:0] vec_count, err_count, first_err_idx;
    logic [9:0] first_err_mask;

    int tests = 0;
    int fails = 0;

    logic [3:0] rv [N];
    logic [9:0] rf [N];
    bit         rgap [N];
    int         rstart_at;

    typedef struct {
        int         pos_a;
        logic [9:0] mask_a;
        int         pos_b;
        logic [9:0] mask_b;
        bit         gaps;
        int         exp_err;
        int         exp_idx;
        logic [9:0] exp_mask;
        bit         exp_pass;
    } vec_t;

    vec_t tbl [6];

    gate_resp_checker dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .vec_valid      (vec_valid),
        .vec_ready      (vec_ready),
        .vec_in         (vec_in),
        .resp_in        (resp_in),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .vec_count      (vec_count),
        .err_count      (err_count),
        .first_err_idx  (first_err_idx),
        .first_err_mask (first_err_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Gate rules restated with sums of input bits rather than logic operators
    function automatic logic [9:0] model(input logic [3:0] v);
        int a = int'(v[3]);
        int b = int'(v[2]);
        int s2 = a + b;
        int s4 = a + b + int'(v[1]) + int'(v[0]);
        logic [9:0] e;
        e[0] = (s2 == 2);
        e[1] = (s2 >= 1);
        e[2] = (s2 == 1);
        e[3] = (s2 != 2);
        e[4] = (s2 == 0);
        e[5] = (s2 != 1);
        e[6] = (a == 0);
        e[7] = (b == 1);
        e[8] = (s4 == 4);
        e[9] = (s4 > 0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] v, input logic [9:0] r, input bit with_start);
        int n = 0;
        @(negedge clk);
        vec_in    = v;
        resp_in   = r;
        vec_valid = 1'b1;
        start     = with_start;
        while (!vec_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!vec_ready) begin
            fails++;
            tests++;
            $display("FAIL ready_timeout: got vec_ready=0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        vec_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    // Plays rv/rf/rgap as one run and scores it against the model
    task automatic play_run();
        int exp_err = 0;
        int exp_idx = 0;
        logic [9:0] exp_mask = '0;
        pulse_start();
        chk("start_clr_done", 32'(done), 32'd0);
        chk("start_clr_cnt", 32'(vec_count), 32'd0);
        for (int i = 0; i < N; i++) begin
            send(rv[i], model(rv[i]) ^ rf[i], (i == rstart_at));
            if (rgap[i]) @(negedge clk);
            if (rf[i] != '0) begin
                if (exp_err == 0) begin
                    exp_idx  = i;
                    exp_mask = rf[i];
                end
                exp_err++;
            end
        end
        wait_done();
        chk("sb_vec_count", 32'(vec_count), 32'(N));
        chk("sb_err_count", 32'(err_count), 32'(exp_err));
        chk("sb_first_idx", 32'(first_err_idx), 32'(exp_idx));
        chk("sb_first_mask", 32'(first_err_mask), 32'(exp_mask));
        chk("sb_pass", 32'(pass), 32'(exp_err == 0));
        chk("sb_busy_done", 32'(busy), 32'd0);
    endtask

    task automatic clear_run();
        for (int i = 0; i < N; i++) begin
            rv[i]   = 4'($urandom_range(0, 15));
            rf[i]   = '0;
            rgap[i] = 1'b0;
        end
        rstart_at = -1;
    endtask

    initial begin
        int rdy_cycles;

        tbl[0] = '{-1, 10'h000, -1, 10'h000, 1'b0, 0, 0,  10'h000, 1'b1};
        tbl[1] = '{ 5, 10'h004, -1, 10'h000, 1'b0, 1, 5,  10'h004, 1'b0};
        tbl[2] = '{ 3, 10'h201,  9, 10'h0F0, 1'b0, 2, 3,  10'h201, 1'b0};
        tbl[3] = '{-1, 10'h000, -1, 10'h000, 1'b1, 0, 0,  10'h000, 1'b1};
        tbl[4] = '{ 0, 10'h3FF, 15, 10'h001, 1'b1, 2, 0,  10'h3FF, 1'b0};
        tbl[5] = '{15, 10'h080, -1, 10'h000, 1'b0, 1, 15, 10'h080, 1'b0};

        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(vec_ready), 32'd0);
        do_reset();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_vec_count", 32'(vec_count), 32'd0);

        for (int t = 0; t < 6; t++) begin
            clear_run();
            rv[5] = 4'b1010;
            for (int i = 0; i < N; i++) begin
                rgap[i] = tbl[t].gaps;
                if (i == tbl[t].pos_a) rf[i] = rf[i] | tbl[t].mask_a;
                if (i == tbl[t].pos_b) rf[i] = rf[i] | tbl[t].mask_b;
            end
            play_run();
            chk($sformatf("tbl%0d_err", t), 32'(err_count), 32'(tbl[t].exp_err));
            chk($sformatf("tbl%0d_idx", t), 32'(first_err_idx), 32'(tbl[t].exp_idx));
            chk($sformatf("tbl%0d_mask", t), 32'(first_err_mask), 32'(tbl[t].exp_mask));
            chk($sformatf("tbl%0d_pass", t), 32'(pass), 32'(tbl[t].exp_pass));
        end

        // valid toggling 0/1 from the first RUN cycle: 32 ready cycles, then FLUSH, then DONE
        pulse_start();
        rdy_cycles = 0;
        for (int c = 0; c < 32; c++) begin
            vec_valid = (c % 2 == 1);
            vec_in    = 4'($urandom_range(0, 15));
            resp_in   = model(vec_in);
            if (vec_ready) rdy_cycles++;
            @(negedge clk);
        end
        vec_valid = 1'b0;
        chk("tog_ready_cycles", 32'(rdy_cycles), 32'd32);
        chk("tog_vec_count", 32'(vec_count), 32'd16);
        chk("tog_flush_ready", 32'(vec_ready), 32'd0);
        chk("tog_flush_busy", 32'(busy), 32'd1);
        chk("tog_flush_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("tog_done", 32'(done), 32'd1);
        chk("tog_pass", 32'(pass), 32'd1);
        chk("tog_busy", 32'(busy), 32'd0);

        // start during RUN must not clear the error already recorded
        clear_run();
        rf[1] = 10'h002;
        rstart_at = 4;
        play_run();
        chk("mid_start_err", 32'(err_count), 32'd1);

        // reset mid-run with a mismatching pair still in the pipeline stage
        clear_run();
        pulse_start();
        for (int i = 0; i < 7; i++) send(rv[i], model(rv[i]) ^ ((i == 6) ? 10'h010 : 10'h000), 1'b0);
        reset_n = 1'b0;
        #1;
        chk("arst_vec_count", 32'(vec_count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(vec_ready), 32'd0);
        chk("arst_err", 32'(err_count), 32'd0);
        chk("arst_done_pass", 32'({done, pass}), 32'd0);
        chk("arst_first", 32'({first_err_idx, first_err_mask}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        vec_valid = 1'b1;
        repeat (3) @(negedge clk);
        vec_valid = 1'b0;
        chk("idle_err_discard", 32'(err_count), 32'd0);
        chk("idle_vec_ignored", 32'(vec_count), 32'd0);
        chk("idle_ready", 32'(vec_ready), 32'd0);
        clear_run();
        play_run();

        for (int r = 0; r < 6; r++) begin
            clear_run();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) rf[i] = 10'($urandom_range(1, 1023));
                rgap[i] = ($urandom_range(0, 2) == 0);
            end
            play_run();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
